debounce_edge: RTL and testbench
================================

Name: debounce_edge

Overview:
- Upstream conditioning stage for the team's D flip-flops and registers.
- Takes a raw, asynchronous, bouncing input (switch or button) and synchronises it to clk.
- Filters it with a stability counter and FSM, then delivers a clean level plus one-cycle rise/fall ticks.
- The q output is intended to drive the d input of a downstream flip-flop or the enable of a counter.

Parameters:
- SYNC_STAGES, 2: number of synchroniser flops on din; legal range >= 2.
- STABLE_CYCLES, 1000: consecutive synchronised cycles at the new level required to accept a change; legal range >= 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset; clears all state immediately.
- din  input  1  raw asynchronous input.
- clear_n  input  1  synchronous, active-low clear of the filter; sampled on the clk rising edge.
- q  output  1  debounced level, registered.
- rise_tick  output  1  one-cycle pulse when q goes 0->1, registered.
- fall_tick  output  1  one-cycle pulse when q goes 1->0, registered.
- busy  output  1  high while a candidate change is being qualified (state is a WAIT state).

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset state: sync chain all 0, state IDLE_LO, cnt=0, q=0, rise_tick=0, fall_tick=0, busy=0.
- Reset takes effect without a clock edge and dominates all other inputs.
- Synchroniser: s = last stage of a SYNC_STAGES-deep flop chain on din. clear_n does not affect the chain.
- Counter: cnt width = $clog2(STABLE_CYCLES); unsigned; never wraps, because it is cleared on every state change.
- FSM states and transitions (evaluated each rising edge when clear_n=1):
  - IDLE_LO: s=1 -> WAIT_HI, cnt=0; else stay.
  - WAIT_HI: s=0 -> IDLE_LO, cnt=0, no tick. s=1 and cnt==STABLE_CYCLES-1 -> IDLE_HI, q<=1, rise_tick<=1. Otherwise cnt<=cnt+1.
  - IDLE_HI: s=0 -> WAIT_LO, cnt=0; else stay.
  - WAIT_LO: mirror of WAIT_HI; on acceptance q<=0, fall_tick<=1.
- Ticks: high for exactly one cycle, in the same cycle q first shows its new value; deasserted on the following edge.
- busy = (state==WAIT_HI) || (state==WAIT_LO), registered with the state.
- Latency: din stable at the new level, first sampled at edge 1 -> q and tick change at edge L = SYNC_STAGES + STABLE_CYCLES + 1.
- A reversal of s at any point during a WAIT state aborts the change; the counter restarts from 0 on the next attempt.
- clear_n=0 at an edge:
  - state forced to IDLE_LO, cnt=0, q=0, ticks=0, busy=0.
  - no fall_tick is generated even if q was 1.
  - clear_n wins over an acceptance occurring on the same edge.
- din already high at reset release: treated as a normal rise; q=1 with rise_tick at edge L after release.
- Reset asserted mid-WAIT: immediate return to the reset state; no tick is emitted.
- No combinational path from din or clear_n to any output.

Decomposition:
- Shared package debounce_pkg holds:
  - state encoding localparams IDLE_LO=2'b00, WAIT_HI=2'b01, IDLE_HI=2'b10, WAIT_LO=2'b11.
  - a helper for the counter width.
- One sub-module, sync_chain: a parameterised SYNC_STAGES-deep flop synchroniser with the same clk and reset. It is reused elsewhere in the codebase.
- FSM, counter and output registers stay in debounce_edge.

Test Plan (SYNC_STAGES=2, STABLE_CYCLES=4, so L=7):
- Reset: assert reset between clock edges with q=1 -> q, rise_tick, fall_tick, busy all 0 before the next edge; they hold 0 while reset is high.
- Clean rise: din 0->1 before edge 1 and held -> busy=1 from edge 3; q=1 and rise_tick=1 after edge 7; rise_tick=0 after edge 8; busy=0 after edge 7.
- Glitch rejection: din high for exactly 3 cycles, then low -> q stays 0, no ticks; busy rises then returns to 0.
- Clean fall: from q=1, din 1->0 held -> q=0 and fall_tick=1 after edge 7, one cycle wide.
- Sync clear: q=1, din high, clear_n=0 for one edge -> q=0 with no fall_tick. After release with din still high: WAIT_HI, then q=1 and rise_tick after 5 edges.
- Reset mid-qualification: din rise, reset pulsed while busy=1 -> all outputs 0 immediately. After release with din high: rise accepted at edge 7, single rise_tick.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types and helpers for the debounce_edge filter: FSM state encoding
// and the stability-counter width calculation.
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE_LO = 2'b00,
        WAIT_HI = 2'b01,
        IDLE_HI = 2'b10,
        WAIT_LO = 2'b11
    } state_t;

    // A counter must hold 0..STABLE_CYCLES-1; never let the width collapse to 0.
    function automatic int cnt_width(input int stable_cycles);
        return (stable_cycles <= 2) ? 1 : $clog2(stable_cycles);
    endfunction

    function automatic logic is_wait(input state_t st);
        return (st == WAIT_HI) || (st == WAIT_LO);
    endfunction

endpackage

// File: rtl/debounce_edge_sync_chain.sv
// Parameterised multi-flop synchroniser for a single asynchronous bit.
// Module name sync_chain so it can be reused by other blocks.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_chain;

    // NOTE: non-blocking assignment so every stage takes its neighbour's old value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/debounce_edge.sv
// Debouncer: synchronises a bouncing input, qualifies each level change for
// STABLE_CYCLES cycles, then drives a clean level plus one-cycle edge ticks.
module debounce_edge
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    input  logic clear_n,
    output logic q,
    output logic rise_tick,
    output logic fall_tick,
    output logic busy
);

    localparam int               CNT_W    = cnt_width(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             w_s;
    logic             w_at_last;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_q;
    logic             w_q_nxt;
    logic             r_rise;
    logic             w_rise_nxt;
    logic             r_fall;
    logic             w_fall_nxt;
    logic             r_busy;
    logic             w_busy_nxt;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (din),
        .o_q   (w_s)
    );

    assign w_at_last = (r_cnt == CNT_LAST);

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_q_nxt     = r_q;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;

        if (!clear_n) begin
            // Clear beats any acceptance on the same edge and emits no tick.
            w_state_nxt = IDLE_LO;
            w_cnt_nxt   = '0;
            w_q_nxt     = 1'b0;
        end else begin
            unique case (r_state)
                IDLE_LO: begin
                    if (w_s) begin
                        w_state_nxt = WAIT_HI;
                        w_cnt_nxt   = '0;
                    end
                end
                WAIT_HI: begin
                    if (!w_s) begin
                        w_state_nxt = IDLE_LO;
                        w_cnt_nxt   = '0;
                    end else if (w_at_last) begin
                        w_state_nxt = IDLE_HI;
                        w_cnt_nxt   = '0;
                        w_q_nxt     = 1'b1;
                        w_rise_nxt  = 1'b1;
                    end else begin
                        w_cnt_nxt   = r_cnt + 1'b1;
                    end
                end
                IDLE_HI: begin
                    if (!w_s) begin
                        w_state_nxt = WAIT_LO;
                        w_cnt_nxt   = '0;
                    end
                end
                WAIT_LO: begin
                    if (w_s) begin
                        w_state_nxt = IDLE_HI;
                        w_cnt_nxt   = '0;
                    end else if (w_at_last) begin
                        w_state_nxt = IDLE_LO;
                        w_cnt_nxt   = '0;
                        w_q_nxt     = 1'b0;
                        w_fall_nxt  = 1'b1;
                    end else begin
                        w_cnt_nxt   = r_cnt + 1'b1;
                    end
                end
            endcase
        end

        w_busy_nxt = is_wait(w_state_nxt);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE_LO;
            r_cnt   <= '0;
            r_q     <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_q     <= w_q_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    assign q         = r_q;
    assign rise_tick = r_rise;
    assign fall_tick = r_fall;
    assign busy      = r_busy;

    // Structural invariants of the output encoding.
    a_ticks_exclusive: assert property (@(posedge clk) disable iff (reset)
        !(rise_tick && fall_tick));
    a_rise_one_cycle: assert property (@(posedge clk) disable iff (reset)
        rise_tick |=> !rise_tick);
    a_fall_one_cycle: assert property (@(posedge clk) disable iff (reset)
        fall_tick |=> !fall_tick);

endmodule

// File: tb/tb_debounce_edge.sv
// Directed bench for debounce_edge with SYNC_STAGES=2, STABLE_CYCLES=4 (L=7):
// a vector table for the steady-state behaviour plus hand-written reset cases.
module tb_debounce_edge;

    logic clk = 1'b0;
    logic reset;
    logic din;
    logic clear_n;
    logic q;
    logic rise_tick;
    logic fall_tick;
    logic busy;

    int n_checks = 0;
    int n_pass   = 0;

    // One record per clock edge: inputs driven before the edge, outputs
    // {q, rise_tick, fall_tick, busy} expected just after it.
    typedef struct packed {
        logic       din;
        logic       clr_n;
        logic [3:0] exp;
        logic [7:0] grp;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] cur_grp;
    string      grp_name [7] = '{"clean_rise", "clean_fall", "glitch",
                                 "rise_again", "sync_clear", "clear_on_fall",
                                 "clear_on_rise"};

    debounce_edge #(
        .SYNC_STAGES   (2),
        .STABLE_CYCLES (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .clear_n   (clear_n),
        .q         (q),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: q/rise/fall/busy got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic add(input logic d, input logic c, input logic [3:0] e);
        vec_t v;
        v.din   = d;
        v.clr_n = c;
        v.exp   = e;
        v.grp   = cur_grp;
        vecs.push_back(v);
    endtask

    initial begin
        logic [3:0] after_rst [8];
        int         n_rise;

        // Rise accepted 7 edges after release with din already high.
        after_rst = '{4'b0000, 4'b0000, 4'b0001, 4'b0001,
                      4'b0001, 4'b0001, 4'b1100, 4'b1000};

        // clean rise: busy from edge 3, q and rise_tick at edge 7
        cur_grp = 8'd0;
        add(1, 1, 4'b0000); add(1, 1, 4'b0000);
        for (int i = 0; i < 4; i++) add(1, 1, 4'b0001);
        add(1, 1, 4'b1100); add(1, 1, 4'b1000);
        // clean fall: fall_tick one cycle at edge 7
        cur_grp = 8'd1;
        add(0, 1, 4'b1000); add(0, 1, 4'b1000);
        for (int i = 0; i < 4; i++) add(0, 1, 4'b1001);
        add(0, 1, 4'b0010); add(0, 1, 4'b0000);
        // glitch: din high for 3 cycles only, counter never reaches 3
        cur_grp = 8'd2;
        add(1, 1, 4'b0000); add(1, 1, 4'b0000); add(1, 1, 4'b0001);
        add(0, 1, 4'b0001); add(0, 1, 4'b0001); add(0, 1, 4'b0000);
        add(0, 1, 4'b0000); add(0, 1, 4'b0000);
        // rise again to set up the clear tests
        cur_grp = 8'd3;
        add(1, 1, 4'b0000); add(1, 1, 4'b0000);
        for (int i = 0; i < 4; i++) add(1, 1, 4'b0001);
        add(1, 1, 4'b1100); add(1, 1, 4'b1000);
        // sync clear with q=1: q drops without fall_tick, rise 5 edges later
        cur_grp = 8'd4;
        add(1, 0, 4'b0000);
        for (int i = 0; i < 4; i++) add(1, 1, 4'b0001);
        add(1, 1, 4'b1100); add(1, 1, 4'b1000);
        // clear on the edge a fall would be accepted: no fall_tick
        cur_grp = 8'd5;
        add(0, 1, 4'b1000); add(0, 1, 4'b1000);
        for (int i = 0; i < 4; i++) add(0, 1, 4'b1001);
        add(0, 0, 4'b0000); add(0, 1, 4'b0000);
        // clear on the edge a rise would be accepted: no rise_tick, restart
        cur_grp = 8'd6;
        add(1, 1, 4'b0000); add(1, 1, 4'b0000);
        for (int i = 0; i < 4; i++) add(1, 1, 4'b0001);
        add(1, 0, 4'b0000);
        for (int i = 0; i < 4; i++) add(1, 1, 4'b0001);
        add(1, 1, 4'b1100); add(1, 1, 4'b1000);

        reset   = 1'b1;
        din     = 1'b0;
        clear_n = 1'b1;
        step();
        step();
        check("reset_state", {q, rise_tick, fall_tick, busy}, 4'b0000);
        reset = 1'b0;

        foreach (vecs[i]) begin
            din     = vecs[i].din;
            clear_n = vecs[i].clr_n;
            step();
            check($sformatf("%s[%0d]", grp_name[vecs[i].grp], i),
                  {q, rise_tick, fall_tick, busy}, vecs[i].exp);
        end

        // Asynchronous reset between edges while q=1, held over two edges.
        #3 reset = 1'b1;
        #1 check("async_reset_q1", {q, rise_tick, fall_tick, busy}, 4'b0000);
        step();
        check("reset_hold_0", {q, rise_tick, fall_tick, busy}, 4'b0000);
        step();
        check("reset_hold_1", {q, rise_tick, fall_tick, busy}, 4'b0000);
        reset = 1'b0;

        // din high at release: qualification starts as a normal rise.
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("release_high[%0d]", i),
                  {q, rise_tick, fall_tick, busy}, after_rst[i]);
        end

        // Reset pulsed mid-WAIT_HI: outputs clear immediately, no tick.
        #3 reset = 1'b1;
        #1 check("reset_mid_wait", {q, rise_tick, fall_tick, busy}, 4'b0000);
        #1 reset = 1'b0;

        n_rise = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (rise_tick) n_rise++;
            check($sformatf("after_mid_reset[%0d]", i),
                  {q, rise_tick, fall_tick, busy}, after_rst[i]);
        end
        check("single_rise_tick", 4'(n_rise), 4'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
